// File: rtl/spu_fetch_buffer_if.sv
// Fetch-buffer bus bundle: redirect from the odd pipe, local-store read port,
// and the instruction-pair handshake toward decode.
interface spu_fetch_buffer_if #(
  parameter int LS_ADDR_WIDTH = 18
);
  logic                     branch_taken;
  logic [31:0]              branch_target;
  logic                     imem_req;
  logic [LS_ADDR_WIDTH-1:0] imem_addr;
  logic [63:0]              imem_rdata;
  logic                     instr_valid;
  logic                     dec_ready;
  logic [31:0]              instr0;
  logic [31:0]              instr1;
  logic                     instr0_valid;
  logic                     instr1_valid;
  logic [31:0]              pair_pc;

  modport master (
    input  branch_taken, branch_target, imem_rdata, dec_ready,
    output imem_req, imem_addr, instr_valid, instr0, instr1,
           instr0_valid, instr1_valid, pair_pc
  );

  modport slave (
    output branch_taken, branch_target, imem_rdata, dec_ready,
    input  imem_req, imem_addr, instr_valid, instr0, instr1,
           instr0_valid, instr1_valid, pair_pc
  );
endinterface

// File: rtl/spu_fetch_buffer.sv
// Instruction fetch and pairing stage: reads 64-bit pairs from local store,
// buffers them in a small FIFO and hands one even/odd pair per cycle to decode.
module spu_fetch_buffer #(
  parameter int DEPTH         = 4,
  parameter int LS_ADDR_WIDTH = 18
) (
  input logic                 clk,
  input logic                 reset,
  spu_fetch_buffer_if.master  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

  typedef logic [LS_ADDR_WIDTH-1:0] addr_t;

  logic [63:0]      fifo_data [DEPTH];
  addr_t            fifo_pc   [DEPTH];
  logic [DEPTH-1:0] fifo_mask;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             inflight;
  logic             squash;
  logic             first_mask;
  addr_t            fetch_pc;
  addr_t            req_pc;
  logic             req_mask;

  addr_t            aligned_pc;
  logic [CNT_W:0]   occupancy;
  logic             issue;
  logic             push;
  logic             pop;
  logic             show;

  // A pop in the same cycle is deliberately not credited to the occupancy.
  always_comb begin
    aligned_pc = {fetch_pc[LS_ADDR_WIDTH-1:3], 3'b000};
    occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    issue      = !reset && !bus.branch_taken && (occupancy < DEPTH_V);
    push       = inflight && !squash;
    show       = !reset && (count != '0);
    pop        = show && !bus.branch_taken && bus.dec_ready;
  end

  always_comb begin
    bus.imem_req     = issue;
    bus.imem_addr    = reset ? '0 : aligned_pc;
    bus.instr_valid  = show && !bus.branch_taken;
    bus.instr0       = '0;
    bus.instr1       = '0;
    bus.pair_pc      = '0;
    bus.instr0_valid = 1'b0;
    bus.instr1_valid = 1'b0;
    if (show) begin
      bus.instr0       = fifo_data[head][63:32];
      bus.instr1       = fifo_data[head][31:0];
      bus.pair_pc      = {{(32 - LS_ADDR_WIDTH){1'b0}}, fifo_pc[head]};
      bus.instr0_valid = !fifo_mask[head];
      bus.instr1_valid = 1'b1;
    end
  end

  // Flush outranks push, pop and issue; the redirect target is aligned only at issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= '0;
      first_mask <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      inflight   <= 1'b0;
      squash     <= 1'b0;
      req_pc     <= '0;
      req_mask   <= 1'b0;
    end else if (bus.branch_taken) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      inflight   <= 1'b0;
      squash     <= inflight;
      fetch_pc   <= bus.branch_target[LS_ADDR_WIDTH-1:0];
      first_mask <= bus.branch_target[2];
    end else begin
      inflight <= issue;
      squash   <= 1'b0;
      if (issue) begin
        fetch_pc   <= aligned_pc + addr_t'(8);
        first_mask <= 1'b0;
        req_pc     <= aligned_pc;
        req_mask   <= first_mask;
      end
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !bus.branch_taken && push) begin
      fifo_data[tail] <= bus.imem_rdata;
      fifo_pc[tail]   <= req_pc;
      fifo_mask[tail] <= req_mask;
    end
  end
endmodule
